// File: rtl/csr_counter_unit.sv
// csr_counter_unit: machine-level Zicsr CSR file with cycle, instret and
// NUM_HPM event counters, mcountinhibit and mscratch.
//
// Ports:
//   clk, rst_n   core clock, asynchronous active-low reset
//   csr_valid    CSR instruction present in EX
//   stall        pipeline hold; blocks CSR writes and instret/HPM increments
//   csr_addr     12-bit CSR address
//   funct3       Zicsr operation
//   rs1_idx      rs1 register index (x0 suppresses set/clear writes)
//   rs1_data     rs1 value (register-source ops)
//   zimm         5-bit immediate (immediate-source ops)
//   retire       one instruction retired this cycle
//   hpm_event    per-counter event strobes
//   csr_rdata    pre-write CSR value, combinational
//   csr_illegal  illegal access, combinational
module csr_counter_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 64,
  parameter int unsigned NUM_HPM    = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   csr_valid,
  input  logic                                   stall,
  input  logic [11:0]                            csr_addr,
  input  logic [2:0]                             funct3,
  input  logic [4:0]                             rs1_idx,
  input  logic [DATA_WIDTH-1:0]                  rs1_data,
  input  logic [4:0]                             zimm,
  input  logic                                   retire,
  input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event,
  output logic [DATA_WIDTH-1:0]                  csr_rdata,
  output logic                                   csr_illegal
);

  // Counter k lives at CSR offset 0 (cycle), 2 (instret), 3+i (hpm i);
  // the same offset is its bit position in mcountinhibit.
  localparam int unsigned NC = 2 + NUM_HPM;
  localparam logic [DATA_WIDTH-1:0] INH_MASK =
    DATA_WIDTH'((((64'd1 << NUM_HPM) - 64'd1) << 3) | 64'd5);

  logic [DATA_WIDTH-1:0] inhibit;
  logic [DATA_WIDTH-1:0] mscratch;

  logic                  u_space, cnt_space, is_inh, is_scr;
  logic                  any_hit, mapped, op_ok, wr_req, illegal, we;
  logic [CNT_WIDTH-1:0]  old_cnt;
  logic [DATA_WIDTH-1:0] src, old_val, new_val;

  // OR-chains collect the addressed counter without a variable array index.
  logic                  hit_or  [NC+1];
  logic [CNT_WIDTH-1:0]  sel_cnt [NC+1];

  assign hit_or[0]  = 1'b0;
  assign sel_cnt[0] = '0;

  assign u_space   = (csr_addr[11:10] == 2'b11);
  assign cnt_space = (csr_addr[11:8] == 4'hC) || (csr_addr[11:8] == 4'hB);
  assign is_inh    = (csr_addr == 12'h320);
  assign is_scr    = (csr_addr == 12'h340);
  assign any_hit   = hit_or[NC];
  assign old_cnt   = sel_cnt[NC];
  assign mapped    = any_hit || is_inh || is_scr;

  assign op_ok   = (funct3[1:0] != 2'b00);
  assign src     = funct3[2] ? DATA_WIDTH'(zimm) : rs1_data;
  assign wr_req  = op_ok && ((funct3[1:0] == 2'b01) ||
                             ((funct3[2] ? zimm : rs1_idx) != 5'd0));
  assign illegal = csr_valid && (!mapped || !op_ok || (wr_req && u_space));
  assign we      = csr_valid && !stall && !illegal && wr_req;

  always_comb begin
    old_val = '0;
    if (any_hit) begin
      old_val = csr_addr[7] ? DATA_WIDTH'(old_cnt >> DATA_WIDTH)
                            : old_cnt[DATA_WIDTH-1:0];
    end else if (is_inh) begin
      old_val = inhibit;
    end else if (is_scr) begin
      old_val = mscratch;
    end

    new_val = old_val;
    case (funct3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  assign csr_rdata   = csr_valid ? old_val : '0;
  assign csr_illegal = illegal;

  for (genvar k = 0; k < NC; k++) begin : g_ctr
    localparam int unsigned SLOT = (k == 0) ? 0 : k + 1;

    logic [CNT_WIDTH-1:0] value;
    logic                 hit;
    logic                 tick;

    assign hit = cnt_space && (csr_addr[6:0] == 7'(SLOT));

    if (k == 0) begin : g_cy
      assign tick = 1'b1;
    end else if (k == 1) begin : g_ir
      assign tick = retire && !stall;
    end else begin : g_hpm
      assign tick = hpm_event[k-2] && !stall;
    end

    // A write replaces one half and suppresses this cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        value <= '0;
      end else if (we && hit) begin
        if (csr_addr[7]) begin
          value[CNT_WIDTH-1:DATA_WIDTH] <= new_val[CNT_WIDTH-DATA_WIDTH-1:0];
        end else begin
          value[DATA_WIDTH-1:0] <= new_val;
        end
      end else if (tick && !inhibit[SLOT]) begin
        value <= value + CNT_WIDTH'(1);
      end
    end

    assign hit_or[k+1]  = hit_or[k] | hit;
    assign sel_cnt[k+1] = sel_cnt[k] | (hit ? value : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inhibit  <= '0;
      mscratch <= '0;
    end else begin
      if (we && is_inh) begin
        inhibit <= new_val & INH_MASK;
      end
      if (we && is_scr) begin
        mscratch <= new_val;
      end
    end
  end

endmodule

// File: tb/tb_csr_counter_unit.sv
module tb_csr_counter_unit;

  localparam int DW = 32;
  localparam int CW = 64;
  localparam int NH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          csr_valid;
  logic          stall;
  logic [11:0]   csr_addr;
  logic [2:0]    funct3;
  logic [4:0]    rs1_idx;
  logic [DW-1:0] rs1_data;
  logic [4:0]    zimm;
  logic          retire;
  logic [NH-1:0] hpm_event;
  logic [DW-1:0] csr_rdata;
  logic          csr_illegal;

  always #5 clk = ~clk;

  csr_counter_unit #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .NUM_HPM    (NH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_valid   (csr_valid),
    .stall       (stall),
    .csr_addr    (csr_addr),
    .funct3      (funct3),
    .rs1_idx     (rs1_idx),
    .rs1_data    (rs1_data),
    .zimm        (zimm),
    .retire      (retire),
    .hpm_event   (hpm_event),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          ill;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: whole 64-bit counters (0 cycle, 1 instret, 2.. hpm).
  logic [63:0] m_ctr [2+NH];
  logic [31:0] m_inh;
  logic [31:0] m_scr;
  string       cur_tag;

  task automatic model_step();
    logic [31:0] old, src, nv;
    logic [63:0] nxt [2+NH];
    bit          found, ro, opok, wr, ill, hi;
    int          tgt, n;
    if (!rst_n) begin
      foreach (m_ctr[i]) m_ctr[i] = '0;
      m_inh = '0;
      m_scr = '0;
    end
    tgt = -1; found = 0; old = '0;
    hi = csr_addr[7];
    if (csr_addr == 12'h320) begin
      found = 1; tgt = 100; old = m_inh;
    end else if (csr_addr == 12'h340) begin
      found = 1; tgt = 101; old = m_scr;
    end else if (csr_addr[11:8] == 4'hB || csr_addr[11:8] == 4'hC) begin
      n = int'(csr_addr[6:0]);
      if (n == 0) tgt = 0;
      else if (n == 2) tgt = 1;
      else if (n >= 3 && n < 3 + NH) tgt = n - 1;
      if (tgt >= 0) begin
        found = 1;
        old = hi ? m_ctr[tgt][63:32] : m_ctr[tgt][31:0];
      end
    end
    ro   = (csr_addr[11:10] == 2'b11);
    opok = (funct3[1:0] != 2'b00);
    src  = funct3[2] ? {27'b0, zimm} : rs1_data;
    wr   = opok && (funct3[1:0] == 2'b01 || rs1_idx != 5'd0);
    ill  = !found || !opok || (wr && ro);
    if (csr_valid) sb.push_back('{old, ill, cur_tag});
    if (!rst_n) return;

    nxt[0] = m_ctr[0] + 64'(!m_inh[0]);
    nxt[1] = m_ctr[1] + 64'(retire && !stall && !m_inh[2]);
    for (int i = 0; i < NH; i++)
      nxt[2+i] = m_ctr[2+i] + 64'(hpm_event[i] && !stall && !m_inh[3+i]);

    case (funct3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    if (csr_valid && !stall && !ill && wr) begin
      if (tgt == 100) m_inh = nv & 32'h0000_001D;
      else if (tgt == 101) m_scr = nv;
      else begin
        nxt[tgt] = m_ctr[tgt];
        if (hi) nxt[tgt][63:32] = nv;
        else    nxt[tgt][31:0]  = nv;
      end
    end
    m_ctr = nxt;
  endtask

  task automatic cyc(input logic v, input logic [11:0] a, input logic [2:0] f,
                     input logic [4:0] idx, input logic [31:0] d,
                     input logic ret, input logic stl, input logic [NH-1:0] ev,
                     input string tag);
    csr_valid = v;  csr_addr = a;  funct3 = f;
    rs1_idx = idx;  zimm = idx;    rs1_data = d;
    retire = ret;   stall = stl;   hpm_event = ev;
    cur_tag = tag;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input string tag);
    cyc(1'b1, a, 3'b010, 5'd0, $urandom, 1'b0, 1'b0, '0, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 12'h000, 3'b000, 5'd0, 32'h0, 1'b0, 1'b0, '0, "idle");
  endtask

  // Monitor: every presented CSR access is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (csr_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: got access with no expected entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        checks += 2;
        if (csr_rdata !== e.rdata) begin
          errors++;
          $display("FAIL %s rdata: got 0x%08h, expected 0x%08h", e.tag, csr_rdata, e.rdata);
        end
        if (csr_illegal !== e.ill) begin
          errors++;
          $display("FAIL %s illegal: got %b, expected %b", e.tag, csr_illegal, e.ill);
        end
      end
    end else begin
      checks++;
      if (csr_rdata !== '0 || csr_illegal !== 1'b0) begin
        errors++;
        $display("FAIL idle_out: got rdata 0x%08h illegal %b, expected 0 and 0", csr_rdata, csr_illegal);
      end
    end
  end

  initial begin
    logic [11:0] alist [21] = '{12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC03, 12'hC83,
                                12'hC04, 12'hC84, 12'hC05, 12'hC01, 12'hB00, 12'hB80,
                                12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04, 12'hB84,
                                12'h320, 12'h340, 12'h7C0};
    logic [11:0] a;
    rst_n = 1'b0; csr_valid = 1'b0; stall = 1'b0; csr_addr = '0; funct3 = '0;
    rs1_idx = '0; rs1_data = '0; zimm = '0; retire = 1'b0; hpm_event = '0;
    foreach (m_ctr[i]) m_ctr[i] = '0;
    m_inh = '0; m_scr = '0; cur_tag = "";
    @(posedge clk); #1;
    idle(3);
    rst_n = 1'b1;

    // Count from reset release.
    idle(10);
    rd(12'hC00, "cycle_after_10");
    rd(12'hC02, "instret_zero");

    // Async reset in the middle of counting.
    cyc(1'b1, 12'h340, 3'b001, 5'd1, 32'h0000_ABCD, 1'b1, 1'b0, '1, "scr_wr");
    while (m_ctr[0] != 64'h37) idle(1);
    rst_n = 1'b0;
    rd(12'hC00, "rst_cycle");
    rd(12'hC80, "rst_cycleh");
    rd(12'hB02, "rst_instret");
    rd(12'h340, "rst_mscratch");
    rd(12'hC03, "rst_hpm3");
    rst_n = 1'b1;

    // Wrap and carry.
    cyc(1'b1, 12'hB00, 3'b001, 5'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, "wr_mcycle");
    cyc(1'b1, 12'hB80, 3'b001, 5'd1, 32'h0, 1'b0, 1'b0, '0, "wr_mcycleh");
    idle(1);
    rd(12'hC00, "carry_lo");
    rd(12'hC80, "carry_hi");
    cyc(1'b1, 12'hB80, 3'b001, 5'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, "wr_mcycleh_ff");
    cyc(1'b1, 12'hB00, 3'b001, 5'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, "wr_mcycle_ff");
    idle(1);
    rd(12'hC00, "wrap_lo");
    rd(12'hC80, "wrap_hi");

    // Read-modify-write on mscratch.
    cyc(1'b1, 12'h340, 3'b001, 5'd7, 32'h0000_F0F0, 1'b0, 1'b0, '0, "scr_rw");
    cyc(1'b1, 12'h340, 3'b010, 5'd5, 32'h0000_000F, 1'b0, 1'b0, '0, "scr_rs");
    rd(12'h340, "scr_after_rs");
    cyc(1'b1, 12'h340, 3'b111, 5'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, "scr_rci");
    rd(12'h340, "scr_after_rci");
    cyc(1'b1, 12'h340, 3'b010, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, "scr_rs_x0");
    rd(12'h340, "scr_unchanged");

    // Illegal accesses.
    cyc(1'b1, 12'hC00, 3'b001, 5'd1, 32'h5, 1'b0, 1'b0, '0, "rw_cycle_ro");
    rd(12'hC00, "cycle_legal_read");
    rd(12'h7C0, "unmapped");
    cyc(1'b1, 12'h340, 3'b100, 5'd1, 32'h1, 1'b0, 1'b0, '0, "funct3_100");
    cyc(1'b1, 12'hB00, 3'b000, 5'd1, 32'h1, 1'b0, 1'b0, '0, "funct3_000");

    // Stall and write priority.
    rd(12'hC02, "instret_pre");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 12'hC00, 3'b010, 5'd0, 32'h0, 1'b1, 1'b1, '1, "stall_cycle");
    rd(12'hC02, "instret_stalled");
    rd(12'hC03, "hpm3_stalled");
    cyc(1'b1, 12'hB02, 3'b001, 5'd2, 32'h100, 1'b1, 1'b0, '0, "wr_minstret");
    rd(12'hC02, "minstret_wins");
    cyc(1'b1, 12'hB02, 3'b001, 5'd2, 32'h55, 1'b0, 1'b1, '0, "wr_minstret_stall");
    rd(12'hC02, "minstret_stall_ign");
    cyc(1'b1, 12'hB82, 3'b001, 5'd2, 32'h7, 1'b1, 1'b0, '0, "wr_minstreth");
    rd(12'hC82, "minstreth");
    rd(12'hC02, "minstret_lo_kept");

    // Count inhibit.
    cyc(1'b1, 12'h320, 3'b001, 5'd2, 32'hFFFF_FFF5, 1'b1, 1'b0, 2'b01, "wr_inhibit");
    rd(12'h320, "inhibit_rd");
    rd(12'hC00, "cy_frozen_a");
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 12'h000, 3'b000, 5'd0, 32'h0, 1'b1, 1'b0, 2'b01, "idle");
    rd(12'hC00, "cy_frozen_b");
    rd(12'hC02, "ir_frozen");
    rd(12'hC03, "hpm3_counts");
    rd(12'hC04, "hpm4_idle");
    cyc(1'b1, 12'h320, 3'b001, 5'd2, 32'h0, 1'b0, 1'b0, '0, "clr_inhibit");
    rd(12'hB00, "cy_resume_a");
    rd(12'hB00, "cy_resume_b");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) a = 12'($urandom);
      else a = alist[$urandom_range(0, 20)];
      cyc(1'($urandom_range(0, 1)), a, 3'($urandom),
          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
          1'($urandom), $urandom_range(0, 4) == 0, NH'($urandom), "random");
    end
    idle(2);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
